// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] MEM_BASE_WADDR = 30'h2000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request payload retained between accept and commit (address kept separately as an index).
  typedef struct packed {
    logic              wen;
    logic [MASK_W-1:0] mask;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Word offset from the window base, at full address width (wraps below base).
  function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
    return addr - base;
  endfunction

  // True when addr lies in [base, base + 2^depth_log2) with no wrap-around.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] offset,
                                         input int unsigned       depth_log2);
    return (addr >= base) && ((offset >> depth_log2) == '0);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request and response channels between the execute stage and memory.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_mask;
  logic [WORD_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_mask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_mask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_byte_ram.sv
// Single-port word array with byte-lane write enables and a registered read port.
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W_RAM = 12
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [MASK_W-1:0]     i_mask,
  input  logic [ADDR_W_RAM-1:0] i_addr,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W_RAM;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // One access per cycle: masked lane write, or whole-word read into the output register.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < int'(MASK_W); i++) begin
          if (i_mask[i]) begin
            r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one request in flight, fixed latency, in-order responses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_WADDR = MEM_BASE_WADDR,
  parameter int unsigned       LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  // Latency needs at least one cycle and must fit the down-counter.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  localparam bit               SHORT     = (LATENCY == 1);
  localparam state_e           ACC_STATE = SHORT ? RESP : WAIT;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);

  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  req_t                    r_req;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_in_range;
  logic                    r_valid;
  logic                    r_err;
  logic                    r_rd_ok;
  logic                    r_live;

  logic [ADDR_W-1:0]       w_live_off;
  logic                    w_live_in;
  req_t                    w_live_req;
  logic                    w_req_ready;
  logic                    w_accept;
  logic                    w_resp_hs;
  logic                    w_commit;
  req_t                    w_c_req;
  logic [DEPTH_LOG2-1:0]   w_c_idx;
  logic                    w_c_in;
  logic [WORD_W-1:0]       w_ram_rdata;

  // Decode the request currently presented on the bus.
  always_comb begin
    w_live_off       = word_offset(bus.req_addr, BASE_WADDR);
    w_live_in        = addr_in_range(bus.req_addr, BASE_WADDR, w_live_off, DEPTH_LOG2);
    w_live_req       = '0;
    w_live_req.wen   = bus.req_wen;
    w_live_req.mask  = bus.req_mask;
    w_live_req.wdata = bus.req_wdata;
  end

  // Ready in IDLE, pass-through of resp_ready in RESP; held low until the first edge after reset.
  assign w_req_ready = r_live & ((r_state == IDLE) | ((r_state == RESP) & bus.resp_ready));
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_resp_hs   = r_valid & bus.resp_ready;

  // Select which request commits on this edge: the live one at unit latency, else the latched one.
  always_comb begin
    w_commit = 1'b0;
    w_c_req  = r_req;
    w_c_idx  = r_idx;
    w_c_in   = r_in_range;
    if (SHORT) begin
      w_commit = w_accept;
      w_c_req  = w_live_req;
      w_c_idx  = w_live_off[DEPTH_LOG2-1:0];
      w_c_in   = w_live_in;
    end else begin
      w_commit = (r_state == WAIT) && (r_cnt == CNT_W'(1));
    end
  end

  mem_byte_ram #(
    .ADDR_W_RAM (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_commit & w_c_in),
    .i_we    (w_c_req.wen),
    .i_mask  (w_c_req.mask),
    .i_addr  (w_c_idx),
    .i_wdata (w_c_req.wdata),
    .o_rdata (w_ram_rdata)
  );

  // Control FSM: accept, count down, present the response until it is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_ok    <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (w_resp_hs) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
          end
        end
        default: ;
      endcase

      if (w_accept) begin
        r_req      <= w_live_req;
        r_idx      <= w_live_off[DEPTH_LOG2-1:0];
        r_in_range <= w_live_in;
        r_cnt      <= CNT_INIT;
        r_state    <= ACC_STATE;
      end

      if (w_commit) begin
        r_valid <= 1'b1;
        r_err   <= ~w_c_in;
        r_rd_ok <= w_c_in & ~w_c_req.wen;
      end
    end
  end

  // Read data is the RAM output register, masked to zero for writes, errors and idle.
  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_valid;
  assign bus.resp_err   = r_err;
  assign bus.resp_rdata = r_rd_ok ? w_ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 instance (A) and LATENCY=1 instance (B).
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if if_a ();
  mem_responder_if if_b ();

  mem_responder #(.DEPTH_LOG2(12), .BASE_WADDR(30'h2000_0000), .LATENCY(LAT_A)) u_dut_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  mem_responder #(.DEPTH_LOG2(6), .BASE_WADDR(30'h2000_0000), .LATENCY(LAT_B)) u_dut_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned appear;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: pops the scoreboard on each response handshake, checks hold stability and latency.
  logic        pa_valid = 1'b0, pa_hs = 1'b0, pa_err = 1'b0;
  logic [31:0] pa_rdata = '0;
  int unsigned pa_appear = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (if_a.resp_valid) begin
      if (!pa_valid || pa_hs) begin
        pa_appear = cyc;
      end else begin
        check("a_hold_rdata", if_a.resp_rdata, pa_rdata);
        check("a_hold_err", 32'(if_a.resp_err), 32'(pa_err));
      end
      if (if_a.resp_ready) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected: response rdata %h err %b, expected none", if_a.resp_rdata, if_a.resp_err);
        end else begin
          e = q_a.pop_front();
          check("a_rdata", if_a.resp_rdata, e.rdata);
          check("a_err", 32'(if_a.resp_err), 32'(e.err));
          check("a_latency_cycle", 32'(pa_appear), 32'(e.appear));
        end
      end
    end
    pa_valid = if_a.resp_valid;
    pa_hs    = if_a.resp_valid & if_a.resp_ready;
    pa_rdata = if_a.resp_rdata;
    pa_err   = if_a.resp_err;
  end

  // Monitor B: same scoreboard checks for the unit-latency instance.
  logic        pb_valid = 1'b0, pb_hs = 1'b0;
  int unsigned pb_appear = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (if_b.resp_valid) begin
      if (!pb_valid || pb_hs) pb_appear = cyc;
      if (if_b.resp_ready) begin
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: response rdata %h err %b, expected none", if_b.resp_rdata, if_b.resp_err);
        end else begin
          e = q_b.pop_front();
          check("b_rdata", if_b.resp_rdata, e.rdata);
          check("b_err", 32'(if_b.resp_err), 32'(e.err));
          check("b_latency_cycle", 32'(pb_appear), 32'(e.appear));
        end
      end
    end
    pb_valid = if_b.resp_valid;
    pb_hs    = if_b.resp_valid & if_b.resp_ready;
  end

  // Present one request, wait (bounded) for acceptance, push the expected response.
  task automatic issue(input bit sel_b, input logic wen, input logic [29:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit push);
    int unsigned guard;
    logic rdy;
    exp_t e;
    @(negedge clk);
    if (sel_b) begin
      if_b.req_valid = 1'b1; if_b.req_wen = wen; if_b.req_addr = addr;
      if_b.req_mask = mask; if_b.req_wdata = wdata;
    end else begin
      if_a.req_valid = 1'b1; if_a.req_wen = wen; if_a.req_addr = addr;
      if_a.req_mask = mask; if_a.req_wdata = wdata;
    end
    #1;
    rdy = sel_b ? if_b.req_ready : if_a.req_ready;
    guard = 0;
    while (!rdy && guard < 100) begin
      @(negedge clk); #1;
      rdy = sel_b ? if_b.req_ready : if_a.req_ready;
      guard++;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready stayed 0 expected 1 (addr %h)", addr);
    end else if (push) begin
      e.rdata  = exp_rdata;
      e.err    = exp_err;
      e.appear = cyc + (sel_b ? LAT_B : LAT_A);
      if (sel_b) q_b.push_back(e);
      else       q_a.push_back(e);
    end
    @(posedge clk); #1;
    if (sel_b) if_b.req_valid = 1'b0;
    else       if_a.req_valid = 1'b0;
  endtask

  task automatic wr_a(input logic [29:0] addr, input logic [3:0] mask, input logic [31:0] d,
                      input logic err);
    issue(1'b0, 1'b1, addr, mask, d, 32'h0, err, 1'b1);
  endtask

  task automatic rd_a(input logic [29:0] addr, input logic [31:0] exp, input logic err);
    issue(1'b0, 1'b0, addr, 4'h0, 32'h0, exp, err, 1'b1);
  endtask

  task automatic drain(input bit sel_b);
    int unsigned guard;
    guard = 0;
    while (((sel_b ? q_b.size() : q_a.size()) != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if ((sel_b ? q_b.size() : q_a.size()) != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses outstanding expected 0",
               sel_b ? q_b.size() : q_a.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] mdl_b [8];

  initial begin
    int unsigned guard;
    if_a.req_valid = 1'b0; if_a.req_wen = 1'b0; if_a.req_addr = '0;
    if_a.req_mask = '0; if_a.req_wdata = '0; if_a.resp_ready = 1'b1;
    if_b.req_valid = 1'b0; if_b.req_wen = 1'b0; if_b.req_addr = '0;
    if_b.req_mask = '0; if_b.req_wdata = '0; if_b.resp_ready = 1'b1;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_resp_valid", 32'(if_a.resp_valid), 32'h0);
    check("rst_a_resp_rdata", if_a.resp_rdata, 32'h0);
    check("rst_a_resp_err", 32'(if_a.resp_err), 32'h0);
    check("rst_a_req_ready", 32'(if_a.req_ready), 32'h0);
    check("rst_b_resp_valid", 32'(if_b.resp_valid), 32'h0);
    check("rst_b_req_ready", 32'(if_b.req_ready), 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_a_req_ready", 32'(if_a.req_ready), 32'h1);
    check("post_rst_b_req_ready", 32'(if_b.req_ready), 32'h1);

    // Write then read
    wr_a(30'h2000_0004, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    rd_a(30'h2000_0004, 32'hDEAD_BEEF, 1'b0);

    // Byte-lane write
    wr_a(30'h2000_0010, 4'b1111, 32'h1122_3344, 1'b0);
    wr_a(30'h2000_0010, 4'b0100, 32'h00AB_0000, 1'b0);
    rd_a(30'h2000_0010, 32'h11AB_3344, 1'b0);

    // Empty mask changes nothing but still answers
    wr_a(30'h2000_0004, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    rd_a(30'h2000_0004, 32'hDEAD_BEEF, 1'b0);

    // Out of range on both sides; an out-of-range write must not alias into index 0
    wr_a(30'h2000_0000, 4'b1111, 32'h0000_1111, 1'b0);
    rd_a(30'h1FFF_FFFF, 32'h0, 1'b1);
    rd_a(30'h2000_1000, 32'h0, 1'b1);
    wr_a(30'h2000_1000, 4'b1111, 32'h5555_5555, 1'b1);
    rd_a(30'h2000_0000, 32'h0000_1111, 1'b0);
    wr_a(30'h2000_0FFF, 4'b1111, 32'h0FFF_0FFF, 1'b0);
    rd_a(30'h2000_0FFF, 32'h0FFF_0FFF, 1'b0);
    drain(1'b0);

    // Backpressure for 5 cycles, then back-to-back accept in the handshake cycle
    @(negedge clk) if_a.resp_ready = 1'b0;
    rd_a(30'h2000_0010, 32'h11AB_3344, 1'b0);
    fork
      rd_a(30'h2000_0004, 32'hDEAD_BEEF, 1'b0);
      begin
        guard = 0;
        while (!if_a.resp_valid && guard < 20) begin
          @(negedge clk); #1;
          guard++;
        end
        repeat (5) begin
          @(negedge clk); #1;
          check("bp_req_ready", 32'(if_a.req_ready), 32'h0);
          check("bp_resp_valid", 32'(if_a.resp_valid), 32'h1);
        end
        @(negedge clk) if_a.resp_ready = 1'b1;
      end
    join
    drain(1'b0);

    // Reset during WAIT drops the pending write
    wr_a(30'h2000_0020, 4'b1111, 32'h1234_5678, 1'b0);
    drain(1'b0);
    issue(1'b0, 1'b1, 30'h2000_0020, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(if_a.resp_valid), 32'h0);
    check("midrst_req_ready", 32'(if_a.req_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_release_req_ready", 32'(if_a.req_ready), 32'h1);
    rd_a(30'h2000_0020, 32'h1234_5678, 1'b0);
    drain(1'b0);

    // Unit-latency sweep: alternating write/read over consecutive words
    for (int k = 0; k < 8; k++) begin
      mdl_b[k] = {8'(k), 8'hC3, 8'(8'hFF - 8'(k)), 8'h5A};
      issue(1'b1, 1'b1, 30'h2000_0010 + 30'(k), 4'b1111, mdl_b[k], 32'h0, 1'b0, 1'b1);
      issue(1'b1, 1'b0, 30'h2000_0010 + 30'(k), 4'b0000, 32'h0, mdl_b[k], 1'b0, 1'b1);
    end
    // Window edge of the 64-word instance
    issue(1'b1, 1'b0, 30'h2000_0040, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 1'b1, 30'h2000_003F, 4'b1111, 32'hA1B2_C3D4, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 30'h2000_003F, 4'b0000, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b1);
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Data-memory responder for the core's load/store port: it is the memory end of the word-addressed, byte-masked interface the execute stage drives.
- Accepts one request at a time through a valid/ready handshake.
- Performs the masked write or the full-word read after a fixed, parameterised latency.
- Returns read data or a write acknowledgement through a second valid/ready handshake.
- Flags out-of-range addresses with an error.
- A thin core-side adapter (out of scope here) replaces the current zero-latency memory model with this block.

Parameters:
DEPTH_LOG2, 12, log2 of number of 32-bit words (default 4096 words = 16 KiB)
BASE_WADDR, 30'h2000_0000, word address of first word (byte address 0x8000_0000)
LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept request this cycle
req_wen  in  1  1 = write, 0 = read
req_addr  in  30  word address (byte address [31:2])
req_mask  in  4  byte-lane write enable, bit i = byte [8i+7:8i]; ignored for reads
req_wdata  in  32  write data, already lane-aligned
resp_valid  out  1  response present
resp_ready  in  1  requester accepts response
resp_rdata  out  32  read data; 0 for writes and errors
resp_err  out  1  address outside [BASE_WADDR, BASE_WADDR + 2^DEPTH_LOG2)

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 0 while rst is low.
  - Latched request and latency counter are cleared.
  - Memory contents are NOT reset.
  - Reset mid-operation drops the pending request silently. A write not yet committed is never committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch wen/addr/mask/wdata and compute the in-range flag.
  - If LATENCY == 1, go to RESP. Otherwise go to WAIT with cnt = LATENCY - 1.
- WAIT:
  - req_ready = 0; cnt decrements each cycle.
  - When cnt == 1, go to RESP on the next edge.
- Commit on the edge that enters RESP:
  - Write: each lane with mask = 1 is updated.
  - Read: the word is sampled into resp_rdata.
  - Out of range: no array access; resp_rdata = 0, resp_err = 1.
- Latency: request accepted at edge T gives resp_valid high in the cycle after edge T + LATENCY - 1, i.e. LATENCY cycles after the accept cycle.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable until resp_valid & resp_ready.
  - req_ready = resp_ready (pass-through), allowing a back-to-back accept in the response handshake cycle.
  - On handshake with a new req_valid: latch the new request and proceed as from IDLE.
  - On handshake without a new request: go to IDLE. resp_valid drops; resp_rdata and resp_err are cleared to 0.
  - Without handshake: stay in RESP; req_valid is not accepted.
- Ordering: strictly in order. A read following a write to the same word returns the post-write value.
- mask = 4'b0000 write: no bytes change; a response is still returned with err = 0.
- Reads ignore req_mask and return the full word. Byte selection is done by the requester.
- Address arithmetic:
  - Index = req_addr - BASE_WADDR, computed at 30 bits.
  - In range iff req_addr >= BASE_WADDR and the index < 2^DEPTH_LOG2; no wrap-around.
  - Array index = low DEPTH_LOG2 bits of the difference.
- Requester-side rule: inputs are sampled only on the accept edge; the requester may change them afterwards.

Decomposition:
- Shared package mem_pkg:
  - State enum (IDLE, WAIT, RESP), 2 bits.
  - Constants: MEM_BASE_WADDR = 30'h2000_0000, WORD_W = 32, MASK_W = 4, CNT_W = 4.
- One sub-module mem_byte_ram:
  - 2^DEPTH_LOG2 x 32 array with 4 byte-lane write enables and a synchronous read port.
  - Single port: one read or one write per cycle.
  - No reset; the top instantiates it once.

Test Plan:
- Write then read, LATENCY = 2: write addr 30'h2000_0004, mask 4'b1111, wdata 32'hDEAD_BEEF, then read the same address.
  -> Write resp_valid 2 cycles after accept, err = 0, rdata = 0; read rdata = 32'hDEAD_BEEF.
- Byte-lane write: write 32'h1122_3344 to addr 30'h2000_0010, then mask 4'b0100 with wdata 32'h00AB_0000.
  -> Read returns 32'h11AB_3344.
- Out of range: read addr 30'h1FFF_FFFF and addr 30'h2000_1000 (DEPTH_LOG2 = 12).
  -> Both give resp_err = 1, rdata = 0, no array access.
  -> A read of 30'h2000_0FFF returns err = 0.
- Backpressure and back-to-back:
  - Hold resp_ready = 0 for 5 cycles. -> resp_valid and rdata stay stable; req_ready = 0.
  - Raise resp_ready with req_valid = 1. -> New request accepted in the same cycle; next resp_valid exactly LATENCY cycles later.
- Reset mid-operation: accept write 32'hCAFE_F00D to addr 30'h2000_0020, assert rst low during WAIT.
  -> resp_valid = 0 immediately; after release req_ready = 1.
  -> A subsequent read returns the prior contents, not CAFE_F00D.
- LATENCY = 1 sweep: 16 alternating writes and reads to consecutive addresses, resp_ready always 1.
  -> One response per 1 cycle after each accept; all read data match a reference model.
